// File: rtl/blitter_write_drain.sv
// blitter_write_drain
//   Drains the blitter write FIFO and merges runs of consecutive word
//   addresses into burst writes (up to BURST_MAX beats) for the SDRAM
//   arbiter. Each beat keeps its own byte enables.
//
// Ports
//   clock, reset        system clock; synchronous active-high reset
//   fifo_address/_byte_en/_data/_valid, fifo_ready
//                       FIFO head entry; popped when fifo_valid && fifo_ready
//   mem_request, mem_address, mem_burst_len, mem_ack
//                       burst request, held until the one-cycle mem_ack grant
//   mem_wvalid, mem_wdata, mem_byte_en, mem_wready
//                       write beats, accepted when mem_wvalid && mem_wready
//   busy                high whenever the block is not idle
//   dbg_state_o         current FSM state, for debug and checkers
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; a valid source holds its payload stable until then.
module blitter_write_drain #(
  parameter int BURST_MAX = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] fifo_address,
  input  logic [3:0]  fifo_byte_en,
  input  logic [31:0] fifo_data,
  input  logic        fifo_valid,
  output logic        fifo_ready,
  output logic        mem_request,
  output logic [25:0] mem_address,
  output logic [4:0]  mem_burst_len,
  input  logic        mem_ack,
  output logic        mem_wvalid,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic        mem_wready,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  localparam int IDXW = $clog2(BURST_MAX);

  typedef enum logic [1:0] {IDLE, COLLECT, REQ, DATA} state_t;

  state_t          state_q, state_d;
  logic [4:0]      count_q;
  logic [25:0]     base_q;
  logic [IDXW-1:0] idx_q;
  logic [35:0]     slot_q [BURST_MAX];

  logic        mem_request_q;
  logic [25:0] mem_address_q;
  logic [4:0]  mem_burst_len_q;
  logic        mem_wvalid_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_byte_en_q;

  logic pop;
  logic contig;
  logic beat_acc;
  logic last_beat;
  logic enter_req;

  // 27-bit sum: a carry out can never match the zero-extended address,
  // so runs never merge across the top of the address space.
  assign contig    = ({1'b0, fifo_address} == ({1'b0, base_q} + 27'(count_q)));
  assign pop       = fifo_valid && fifo_ready;
  assign beat_acc  = mem_wvalid_q && mem_wready;
  assign last_beat = (5'(idx_q) == (count_q - 5'd1));
  assign enter_req = (state_q == COLLECT) && (state_d == REQ);

  always_comb begin
    fifo_ready = 1'b0;
    state_d    = state_q;
    if (!reset) begin
      case (state_q)
        IDLE:    fifo_ready = 1'b1;
        COLLECT: fifo_ready = fifo_valid && (count_q < 5'(BURST_MAX)) && contig;
        default: fifo_ready = 1'b0;
      endcase
    end
    case (state_q)
      IDLE: begin
        if (pop) state_d = COLLECT;
      end
      COLLECT: begin
        // No waiting for more data: a stall or a gap closes the burst.
        if (!pop || (count_q == 5'(BURST_MAX - 1))) state_d = REQ;
      end
      REQ: begin
        if (mem_ack) state_d = DATA;
      end
      DATA: begin
        if (beat_acc && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      count_q         <= '0;
      base_q          <= '0;
      idx_q           <= '0;
      mem_request_q   <= 1'b0;
      mem_address_q   <= '0;
      mem_burst_len_q <= '0;
      mem_wvalid_q    <= 1'b0;
      mem_wdata_q     <= '0;
      mem_byte_en_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        count_q <= count_q + 5'd1;
        if (state_q == IDLE) base_q <= fifo_address;
      end
      if (enter_req) begin
        mem_request_q   <= 1'b1;
        mem_address_q   <= base_q;
        mem_burst_len_q <= pop ? (count_q + 5'd1) : count_q;
      end
      if ((state_q == REQ) && mem_ack) begin
        mem_request_q                <= 1'b0;
        mem_wvalid_q                 <= 1'b1;
        {mem_byte_en_q, mem_wdata_q} <= slot_q[0];
        idx_q                        <= '0;
      end
      if ((state_q == DATA) && beat_acc) begin
        if (last_beat) begin
          mem_wvalid_q <= 1'b0;
          count_q      <= '0;
        end else begin
          idx_q                        <= idx_q + 1'b1;
          {mem_byte_en_q, mem_wdata_q} <= slot_q[idx_q + 1'b1];
        end
      end
    end
  end

  // Buffer storage carries no reset; count_q alone says what is valid.
  always_ff @(posedge clock) begin
    if (pop) slot_q[count_q[IDXW-1:0]] <= {fifo_byte_en, fifo_data};
  end

  assign mem_request   = mem_request_q;
  assign mem_address   = mem_address_q;
  assign mem_burst_len = mem_burst_len_q;
  assign mem_wvalid    = mem_wvalid_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_byte_en   = mem_byte_en_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_blitter_write_drain.sv
module tb_blitter_write_drain;

  localparam int BM = 8;

  logic        clock;
  logic        reset;
  logic [25:0] fifo_address;
  logic [3:0]  fifo_byte_en;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;
  logic        mem_request;
  logic [25:0] mem_address;
  logic [4:0]  mem_burst_len;
  logic        mem_ack;
  logic        mem_wvalid;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_wready;
  logic        busy;
  logic [1:0]  dbg_state;

  blitter_write_drain #(.BURST_MAX(BM)) dut (
    .clock(clock), .reset(reset),
    .fifo_address(fifo_address), .fifo_byte_en(fifo_byte_en),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .mem_request(mem_request), .mem_address(mem_address),
    .mem_burst_len(mem_burst_len), .mem_ack(mem_ack),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_wready(mem_wready), .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  // source FIFO contents {addr[61:36], byte_en[35:32], data[31:0]}
  logic [61:0] src_q[$];
  // scoreboard: expected beats {byte_en, data} and bursts {addr, len}
  logic [35:0] exp_q[$];
  logic [30:0] exp_burst_q[$];

  bit          stall_en;
  int          beats_left;
  int          beats_done;
  bit          expect_idle;
  bit          prev_req_hold;
  bit          prev_beat_hold;
  logic [25:0] prev_addr;
  logic [4:0]  prev_len;
  logic [35:0] prev_beat;

  // Reference model: with the source FIFO preloaded and never running dry
  // mid-run, bursts are a greedy split of the entry list into runs of
  // consecutive word addresses (no wrap past 0x3FFFFFF), at most BM long.
  task automatic build_model();
    int n;
    int i;
    int len;
    longint a0;
    n = src_q.size();
    i = 0;
    while (i < n) begin
      a0  = longint'(src_q[i][61:36]);
      len = 1;
      while ((i + len < n) && (len < BM) &&
             (longint'(src_q[i+len][61:36]) == a0 + len))
        len++;
      exp_burst_q.push_back({src_q[i][61:36], 5'(len)});
      for (int k = 0; k < len; k++) exp_q.push_back(src_q[i+k][35:0]);
      i += len;
    end
  endtask

  task automatic push_entry(input logic [25:0] a, input logic [3:0] be,
                            input logic [31:0] d);
    src_q.push_back({a, be, d});
  endtask

  task automatic clear_tracking();
    src_q.delete();
    exp_q.delete();
    exp_burst_q.delete();
    beats_left     = 0;
    expect_idle    = 0;
    prev_req_hold  = 0;
    prev_beat_hold = 0;
  endtask

  // One clock: sample/drive at negedge, record handshakes for the next posedge.
  task automatic cycle();
    logic [30:0] eb;
    logic [35:0] eq;
    @(negedge clock);
    if (prev_req_hold) begin
      total++;
      if (mem_request !== 1'b1 || mem_address !== prev_addr || mem_burst_len !== prev_len) begin
        bad++;
        $display("FAIL req_hold: req=%b addr=%h len=%0d, required req=1 addr=%h len=%0d",
                 mem_request, mem_address, mem_burst_len, prev_addr, prev_len);
      end
    end
    if (prev_beat_hold) begin
      total++;
      if (mem_wvalid !== 1'b1 || {mem_byte_en, mem_wdata} !== prev_beat) begin
        bad++;
        $display("FAIL beat_hold: wvalid=%b beat=%h, required wvalid=1 beat=%h",
                 mem_wvalid, {mem_byte_en, mem_wdata}, prev_beat);
      end
    end
    if (expect_idle) begin
      total++;
      if (busy !== 1'b0 || mem_wvalid !== 1'b0) begin
        bad++;
        $display("FAIL busy_drop: busy=%b wvalid=%b, required 0 0", busy, mem_wvalid);
      end
    end
    // drive
    if (src_q.size() > 0) begin
      fifo_valid = 1'b1;
      {fifo_address, fifo_byte_en, fifo_data} = src_q[0];
    end else begin
      fifo_valid   = 1'b0;
      fifo_address = 26'($urandom);
      fifo_byte_en = 4'($urandom);
      fifo_data    = $urandom;
    end
    if (mem_request) mem_ack = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
    else             mem_ack = stall_en && ($urandom_range(0, 5) == 0);
    mem_wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (fifo_valid && fifo_ready) void'(src_q.pop_front());
    prev_req_hold = mem_request && !mem_ack;
    prev_addr     = mem_address;
    prev_len      = mem_burst_len;
    if (mem_request && mem_ack) begin
      total++;
      if (exp_burst_q.size() == 0) begin
        bad++;
        $display("FAIL burst_extra: addr=%h len=%0d, required no burst", mem_address, mem_burst_len);
      end else begin
        eb = exp_burst_q.pop_front();
        if ({mem_address, mem_burst_len} !== eb) begin
          bad++;
          $display("FAIL burst: addr=%h len=%0d, required addr=%h len=%0d",
                   mem_address, mem_burst_len, eb[30:5], eb[4:0]);
        end
        beats_left = int'(eb[4:0]);
      end
    end
    expect_idle = 0;
    if (mem_wvalid && mem_wready) begin
      total++;
      beats_done++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_extra: beat=%h, required none", {mem_byte_en, mem_wdata});
      end else begin
        eq = exp_q.pop_front();
        if ({mem_byte_en, mem_wdata} !== eq) begin
          bad++;
          $display("FAIL beat: be=%h data=%h, required be=%h data=%h",
                   mem_byte_en, mem_wdata, eq[35:32], eq[31:0]);
        end
      end
      beats_left--;
      if (beats_left == 0) expect_idle = 1;
    end
    prev_beat_hold = mem_wvalid && !mem_wready;
    prev_beat      = {mem_byte_en, mem_wdata};
  endtask

  task automatic run_batch(input string name);
    int cyc;
    build_model();
    cyc = 0;
    while (cyc < 3000 && (src_q.size() > 0 || exp_q.size() > 0 ||
                          exp_burst_q.size() > 0 || busy !== 1'b0 || expect_idle)) begin
      cycle();
      cyc++;
    end
    total++;
    if (cyc >= 3000) begin
      bad++;
      $display("FAIL %s_timeout: beats left=%0d bursts left=%0d, required 0 0",
               name, exp_q.size(), exp_burst_q.size());
      clear_tracking();
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    fifo_valid   = 1'b1;
    fifo_address = 26'h0000100;
    fifo_byte_en = 4'hF;
    fifo_data    = 32'h12345678;
    mem_ack      = 1'b0;
    mem_wready   = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (fifo_ready !== 1'b0 || mem_request !== 1'b0 || mem_wvalid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%b req=%b wvalid=%b busy=%b, required 0 0 0 0",
               fifo_ready, mem_request, mem_wvalid, busy);
    end
    total++;
    if (mem_address !== 26'd0 || mem_burst_len !== 5'd0 || mem_wdata !== 32'd0 || mem_byte_en !== 4'd0) begin
      bad++;
      $display("FAIL reset_data: addr=%h len=%0d data=%h be=%h, required all 0",
               mem_address, mem_burst_len, mem_wdata, mem_byte_en);
    end
    fifo_valid = 1'b0;
    reset      = 1'b0;
    clear_tracking();
  endtask

  task automatic test_single();
    stall_en = 0;
    push_entry(26'h0000100, 4'b1111, 32'hDEADBEEF);
    run_batch("single");
  endtask

  task automatic test_full_burst();
    stall_en = 0;
    for (int i = 0; i < 8; i++) push_entry(26'h0001000 + 26'(i), 4'hF, 32'(i));
    run_batch("full_burst");
  endtask

  task automatic test_back_to_back();
    stall_en = 0;
    for (int i = 0; i < 10; i++) push_entry(26'h0002000 + 26'(i), 4'hF, 32'hA000 + 32'(i));
    run_batch("back_to_back");
  endtask

  task automatic test_byte_en();
    stall_en = 0;
    push_entry(26'h10, 4'h1, 32'h11111111);
    push_entry(26'h11, 4'h2, 32'h22222222);
    push_entry(26'h20, 4'h4, 32'h33333333);
    push_entry(26'h21, 4'h8, 32'h44444444);
    run_batch("byte_en");
  endtask

  task automatic test_wrap();
    stall_en = 1;
    push_entry(26'h3FFFFFF, 4'h0, 32'hCAFEF00D);
    push_entry(26'h0000000, 4'h5, 32'h0BADF00D);
    run_batch("wrap");
  endtask

  task automatic test_random();
    logic [25:0] a;
    stall_en = 1;
    for (int b = 0; b < 12; b++) begin
      a = 26'($urandom);
      for (int i = 0; i < $urandom_range(3, 24); i++) begin
        if ($urandom_range(0, 3) == 0) a = 26'($urandom);
        else if ($urandom_range(0, 15) == 0) a = 26'h3FFFFFF;
        else if (i > 0) a = a + 26'd1;
        push_entry(a, 4'($urandom), $urandom);
      end
      run_batch("random");
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    stall_en = 0;
    for (int i = 0; i < 8; i++) push_entry(26'h0003000 + 26'(i), 4'hF, 32'hB000 + 32'(i));
    build_model();
    beats_done = 0;
    cyc = 0;
    while (beats_done < 3 && cyc < 200) begin
      cycle();
      cyc++;
    end
    total++;
    if (beats_done < 3) begin
      bad++;
      $display("FAIL mid_reset_timeout: beats=%0d, required 3", beats_done);
    end
    @(negedge clock);
    reset      = 1'b1;
    fifo_valid = 1'b0;
    mem_ack    = 1'b0;
    mem_wready = 1'b1;
    @(negedge clock);
    total++;
    if (mem_wvalid !== 1'b0 || mem_request !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: wvalid=%b req=%b busy=%b, required 0 0 0",
               mem_wvalid, mem_request, busy);
    end
    reset = 1'b0;
    clear_tracking();
    test_single();
  endtask

  initial begin
    stall_en   = 0;
    beats_done = 0;
    clear_tracking();
    test_reset();
    test_single();
    test_full_burst();
    test_back_to_back();
    test_byte_en();
    test_wrap();
    test_random();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
